// File: rtl/ysyx_23060236_store_buffer.sv
// Posted-write buffer between the LSU write channels and the xbar LSU write port.
// Stores are acknowledged early and drained in order, one single-beat AXI4 write at a time.
module ysyx_23060236_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_awaddr,
  input  logic [2:0]  in_awsize,
  input  logic        in_awvalid,
  output logic        in_awready,
  input  logic [31:0] in_wdata,
  input  logic [3:0]  in_wstrb,
  input  logic        in_wvalid,
  output logic        in_wready,
  output logic [1:0]  in_bresp,
  output logic        in_bvalid,
  input  logic        in_bready,
  input  logic [31:0] ld_araddr,
  input  logic        ld_arvalid,
  output logic        ld_hazard,
  output logic [31:0] out_awaddr,
  output logic [2:0]  out_awsize,
  output logic [7:0]  out_awlen,
  output logic [1:0]  out_awburst,
  output logic [3:0]  out_awid,
  output logic        out_awvalid,
  input  logic        out_awready,
  output logic [31:0] out_wdata,
  output logic [3:0]  out_wstrb,
  output logic        out_wlast,
  output logic        out_wvalid,
  input  logic        out_wready,
  input  logic [1:0]  out_bresp,
  input  logic        out_bvalid,
  output logic        out_bready,
  output logic        drained,
  output logic        wr_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [31:0]      addr_q [DEPTH];
  logic [2:0]       size_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [3:0]       strb_q [DEPTH];
  logic [DEPTH-1:0] vld_q;

  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q;
  logic             bvalid_q;
  logic             wr_err_q;
  state_t           state_q, state_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;

  logic             full;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] push_mask;
  logic [DEPTH-1:0] pop_mask;
  logic             buf_hit;
  logic             aw_hit;
  logic             unused_ld_lsb;

  assign full       = (count_q == FULL_CNT);
  assign in_awready = in_awvalid & in_wvalid & ~full & ~bvalid_q;
  assign in_wready  = in_awready;
  assign push       = in_awready;
  assign pop        = (state_q == S_RESP) & out_bvalid;
  assign push_mask  = push ? (DEPTH'(1) << tail_q) : '0;
  assign pop_mask   = pop  ? (DEPTH'(1) << head_q) : '0;

  assign in_bresp  = 2'b00;
  assign in_bvalid = bvalid_q;
  assign wr_err    = wr_err_q;

  // Entry payload needs no reset; occupancy is tracked by vld_q and count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= in_awaddr;
      size_q[tail_q] <= in_awsize;
      data_q[tail_q] <= in_wdata;
      strb_q[tail_q] <= in_wstrb;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      vld_q    <= '0;
      bvalid_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      vld_q <= (vld_q | push_mask) & ~pop_mask;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push)
        bvalid_q <= 1'b1;
      else if (bvalid_q & in_bready)
        bvalid_q <= 1'b0;
      if (pop && (out_bresp != 2'b00))
        wr_err_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Each channel's valid drops on its own handshake; RESP once both have completed.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    out_awvalid = 1'b0;
    out_wvalid  = 1'b0;
    out_bready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (count_q != '0) state_d = S_REQ;
      end
      S_REQ: begin
        out_awvalid = ~aw_done_q;
        out_wvalid  = ~w_done_q;
        aw_done_d   = aw_done_q | out_awready;
        w_done_d    = w_done_q | out_wready;
        if (aw_done_d && w_done_d) state_d = S_RESP;
      end
      S_RESP: begin
        out_bready = 1'b1;
        if (out_bvalid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign out_awaddr  = addr_q[head_q];
  assign out_awsize  = size_q[head_q];
  assign out_awlen   = 8'd0;
  assign out_awburst = 2'b01;
  assign out_awid    = 4'd0;
  assign out_wdata   = data_q[head_q];
  assign out_wstrb   = strb_q[head_q];
  assign out_wlast   = 1'b1;

  // Word-granular match against every occupied entry plus the store being offered now.
  always_comb begin
    buf_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      buf_hit = buf_hit | (vld_q[i] & (addr_q[i][31:2] == ld_araddr[31:2]));
  end

  assign aw_hit        = in_awvalid & (in_awaddr[31:2] == ld_araddr[31:2]);
  assign ld_hazard     = ld_arvalid & (buf_hit | aw_hit);
  assign unused_ld_lsb = ^ld_araddr[1:0];

  assign drained = (count_q == '0) & (state_q == S_IDLE) & ~bvalid_q;

endmodule
